// File: rtl/inning_sequencer.sv
// Game-flow controller: ball/strike count, out/walk pulses to the out-count block,
// half-inning change-over hold and inning advance up to game over.
module inning_sequencer #(
  parameter int MAX_INNING  = 9,
  parameter int HOLD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       strike_pulse,
  input  logic       foul_pulse,
  input  logic       ball_pulse,
  input  logic       hit_pulse,
  input  logic       outreq_pulse,
  input  logic       newgame_pulse,
  input  logic       change_pulse,
  output logic       out_pulse,
  output logic       walk_pulse,
  output logic [2:0] ball_led,
  output logic [1:0] strike_led,
  output logic       bottom_half,
  output logic [3:0] inning,
  output logic       game_over,
  output logic [1:0] state_o
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [3:0] LAST_INNING = 4'(MAX_INNING);

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    SETTLE    = 2'd1,
    HOLD      = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  state_t          state_q, state_d;
  // Counts are kept directly in thermometer form so the LEDs are plain flops.
  logic [2:0]      balls_q, balls_d;
  logic [1:0]      strikes_q, strikes_d;
  logic [3:0]      inning_q, inning_d;
  logic            bottom_q, bottom_d;
  logic            out_q, out_d;
  logic            walk_q, walk_d;
  logic            over_q, over_d;
  logic            settle_q, settle_d;
  logic [HW-1:0]   hold_q, hold_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= PLAY;
      balls_q   <= 3'b000;
      strikes_q <= 2'b00;
      inning_q  <= 4'd1;
      bottom_q  <= 1'b0;
      out_q     <= 1'b0;
      walk_q    <= 1'b0;
      over_q    <= 1'b0;
      settle_q  <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      balls_q   <= balls_d;
      strikes_q <= strikes_d;
      inning_q  <= inning_d;
      bottom_q  <= bottom_d;
      out_q     <= out_d;
      walk_q    <= walk_d;
      over_q    <= over_d;
      settle_q  <= settle_d;
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    balls_d   = balls_q;
    strikes_d = strikes_q;
    inning_d  = inning_q;
    bottom_d  = bottom_q;
    out_d     = 1'b0;
    walk_d    = 1'b0;
    settle_d  = settle_q;
    hold_d    = hold_q;

    case (state_q)
      PLAY, SETTLE: begin
        if (change_pulse) begin
          balls_d   = 3'b000;
          strikes_d = 2'b00;
          hold_d    = HOLD_LOAD;
          state_d   = HOLD;
        end else if (state_q == SETTLE) begin
          // Two quiet cycles give the out-count block time to raise change_pulse.
          if (settle_q) settle_d = 1'b0;
          else          state_d  = PLAY;
        end else if (outreq_pulse || (strike_pulse && strikes_q[1])) begin
          out_d     = 1'b1;
          balls_d   = 3'b000;
          strikes_d = 2'b00;
          settle_d  = 1'b1;
          state_d   = SETTLE;
        end else if (strike_pulse) begin
          strikes_d = {strikes_q[0], 1'b1};
        end else if (foul_pulse) begin
          strikes_d = {strikes_q[0], 1'b1};
        end else if (ball_pulse) begin
          if (balls_q[2]) begin
            walk_d    = 1'b1;
            balls_d   = 3'b000;
            strikes_d = 2'b00;
          end else begin
            balls_d = {balls_q[1:0], 1'b1};
          end
        end else if (hit_pulse) begin
          balls_d   = 3'b000;
          strikes_d = 2'b00;
        end
      end
      HOLD: begin
        if (hold_q == '0) begin
          if (!bottom_q) begin
            bottom_d = 1'b1;
            state_d  = PLAY;
          end else if (inning_q == LAST_INNING) begin
            state_d = GAME_OVER;
          end else begin
            bottom_d = 1'b0;
            inning_d = inning_q + 4'd1;
            state_d  = PLAY;
          end
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      GAME_OVER: begin
        if (newgame_pulse) begin
          balls_d   = 3'b000;
          strikes_d = 2'b00;
          inning_d  = 4'd1;
          bottom_d  = 1'b0;
          settle_d  = 1'b0;
          hold_d    = '0;
          state_d   = PLAY;
        end
      end
      default: state_d = PLAY;
    endcase

    over_d = (state_d == GAME_OVER);
  end

  assign out_pulse   = out_q;
  assign walk_pulse  = walk_q;
  assign ball_led    = balls_q;
  assign strike_led  = strikes_q;
  assign bottom_half = bottom_q;
  assign inning      = inning_q;
  assign game_over   = over_q;
  assign state_o     = state_q;

endmodule
